// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES result path to/from the UART.
// Holds framing constants, the framer state encoding and the block byte selector.
package aes_uart_pkg;

    localparam logic [7:0]  AES_CR          = 8'h0D;
    localparam logic [7:0]  AES_LF          = 8'h0A;
    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned AES_BLOCK_BITS  = 8 * AES_BLOCK_BYTES;
    localparam int unsigned AES_IDX_W       = 5;

    typedef enum logic [1:0] {
        FR_IDLE = 2'd0,
        FR_SEND = 2'd1,
        FR_GAP  = 2'd2,
        FR_FIN  = 2'd3
    } framer_state_e;

    // Byte idx of a block, byte 0 being the most significant.
    function automatic logic [7:0] aes_byte_sel(input logic [AES_BLOCK_BITS-1:0] blk,
                                                input logic [3:0]                idx);
        logic [3:0] rev;
        rev = 4'd15 - idx;
        return blk[{rev, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_tx_framer_if.sv
// Block-in / byte-out handshake bundle between AES core, framer and uart_txd.
interface aes_tx_framer_if;
    import aes_uart_pkg::*;

    logic                      blk_valid;
    logic [AES_BLOCK_BITS-1:0] blk_data;
    logic                      tx_en;
    logic [7:0]                tx_data;
    logic                      tx_done;
    logic                      busy;
    logic                      send_done;
    logic                      overflow;

    modport master (
        input  blk_valid, blk_data, tx_done,
        output tx_en, tx_data, busy, send_done, overflow
    );

    modport slave (
        output blk_valid, blk_data, tx_done,
        input  tx_en, tx_data, busy, send_done, overflow
    );

endinterface

// File: rtl/aes_tx_framer.sv
// Captures AES result blocks (one active, one pending) and serialises them
// MSB-first to uart_txd with an optional CR/LF trailer.
module aes_tx_framer
    import aes_uart_pkg::*;
#(
    parameter bit TRAILER_EN = 1'b1
) (
    input  logic            sys_clk,
    input  logic            NRST,
    aes_tx_framer_if.master bus
);

    localparam int unsigned FRAME_BYTES = TRAILER_EN ? AES_BLOCK_BYTES + 2 : AES_BLOCK_BYTES;
    localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(FRAME_BYTES - 1);
    localparam logic [AES_IDX_W-1:0] CR_IDX   = AES_IDX_W'(AES_BLOCK_BYTES);

    framer_state_e             state_q,     state_d;
    logic [AES_BLOCK_BITS-1:0] active_q,    active_d;
    logic [AES_BLOCK_BITS-1:0] pend_q,      pend_d;
    logic                      pend_vld_q,  pend_vld_d;
    logic [AES_IDX_W-1:0]      idx_q,       idx_d;
    logic                      tx_en_q,     tx_en_d;
    logic [7:0]                tx_data_q,   tx_data_d;
    logic                      busy_q,      busy_d;
    logic                      send_done_q, send_done_d;
    logic                      overflow_q,  overflow_d;

    // Data bytes come from the block; indices past the block map to the trailer.
    function automatic logic [7:0] frame_byte(input logic [AES_BLOCK_BITS-1:0] blk,
                                              input logic [AES_IDX_W-1:0]      idx);
        if (idx == CR_IDX) begin
            return AES_CR;
        end else if (idx > CR_IDX) begin
            return AES_LF;
        end
        return aes_byte_sel(blk, idx[3:0]);
    endfunction

    always_ff @(posedge sys_clk) begin
        if (!NRST) begin
            state_q     <= FR_IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            idx_q       <= '0;
            tx_en_q     <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            send_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            idx_q       <= idx_d;
            tx_en_q     <= tx_en_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            send_done_q <= send_done_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        idx_d      = idx_q;
        overflow_d = 1'b0;

        case (state_q)
            FR_IDLE: begin
                if (bus.blk_valid) begin
                    active_d = bus.blk_data;
                    idx_d    = '0;
                    state_d  = FR_SEND;
                end
            end

            FR_SEND, FR_GAP: begin
                if (state_q == FR_GAP) begin
                    state_d = FR_SEND;
                end else if (bus.tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FR_FIN;
                    end else begin
                        idx_d   = idx_q + AES_IDX_W'(1);
                        state_d = FR_GAP;
                    end
                end
                // A block arriving mid-frame waits in pending; a third one is lost.
                if (bus.blk_valid) begin
                    if (!pend_vld_q) begin
                        pend_d     = bus.blk_data;
                        pend_vld_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end

            FR_FIN: begin
                if (pend_vld_q) begin
                    active_d = pend_q;
                    idx_d    = '0;
                    state_d  = FR_SEND;
                    if (bus.blk_valid) begin
                        pend_d = bus.blk_data;
                    end else begin
                        pend_vld_d = 1'b0;
                    end
                end else if (bus.blk_valid) begin
                    active_d = bus.blk_data;
                    idx_d    = '0;
                    state_d  = FR_SEND;
                end else begin
                    state_d = FR_IDLE;
                end
            end

            default: begin
                state_d = FR_IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they register with it.
        tx_en_d     = (state_d == FR_SEND);
        tx_data_d   = tx_en_d ? frame_byte(active_d, idx_d) : tx_data_q;
        send_done_d = (state_d == FR_FIN);
        busy_d      = (state_d != FR_IDLE) || pend_vld_d;
    end

    assign bus.tx_en     = tx_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.send_done = send_done_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_aes_tx_framer.sv
// Bench for aes_tx_framer: two instances (trailer on/off) fed the same blocks,
// each with its own uart_txd responder, reference model and monitor.
module tb_aes_tx_framer;

    logic         sys_clk;
    logic         nrst;
    logic         blk_valid;
    logic [127:0] blk_data;
    int           n_checks;
    int           n_fail;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst %0d] at %0t: got 0x%0h, expected 0x%0h",
                     name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit          TRL = (g == 0);
        localparam int unsigned FB  = TRL ? 18 : 16;

        aes_tx_framer_if bus ();
        logic       real_done;
        logic       spur_done;
        logic [7:0] exp_q[$];
        int         outstanding;
        int         seen;
        int         n_rise;
        int         n_ovf;
        logic       exp_fin, exp_ovf, gap_now, rise_now, rise_next;

        assign bus.blk_valid = blk_valid;
        assign bus.blk_data  = blk_data;
        assign bus.tx_done   = real_done | spur_done;

        aes_tx_framer #(.TRAILER_EN(TRL)) u_dut (
            .sys_clk (sys_clk),
            .NRST    (nrst),
            .bus     (bus)
        );

        // uart_txd stand-in: acknowledges each byte after a delay, injects stray tx_done when not sending.
        initial begin : resp
            int   wait_c;
            logic prev_en;
            wait_c    = -1;
            prev_en   = 1'b0;
            real_done = 1'b0;
            spur_done = 1'b0;
            forever begin
                @(negedge sys_clk);
                real_done = 1'b0;
                spur_done = 1'b0;
                if (!nrst || !bus.tx_en) begin
                    wait_c = -1;
                    if (nrst) begin
                        if (prev_en && !bus.send_done && $urandom_range(0, 1) == 1)
                            spur_done = 1'b1;
                        else if (!bus.busy && $urandom_range(0, 15) == 0)
                            spur_done = 1'b1;
                    end
                end else begin
                    if (wait_c < 0) wait_c = (g == 0) ? int'($urandom_range(0, 9)) : 9;
                    if (wait_c == 0) begin
                        real_done = 1'b1;
                        wait_c    = -1;
                    end else begin
                        wait_c--;
                    end
                end
                prev_en = bus.tx_en;
            end
        end

        // Reference model: at most two blocks held; a block is released once its last byte is acknowledged.
        initial begin : model
            outstanding = 0;
            seen        = 0;
            exp_fin     = 1'b0;
            exp_ovf     = 1'b0;
            gap_now     = 1'b0;
            rise_now    = 1'b0;
            rise_next   = 1'b0;
            forever begin
                @(posedge sys_clk);
                exp_fin   = 1'b0;
                exp_ovf   = 1'b0;
                gap_now   = 1'b0;
                rise_now  = rise_next;
                rise_next = 1'b0;
                if (!nrst) begin
                    exp_q.delete();
                    outstanding = 0;
                    seen        = 0;
                    rise_now    = 1'b0;
                end else begin
                    if (blk_valid) begin
                        if (outstanding < 2) begin
                            if (outstanding == 0) rise_now = 1'b1;
                            outstanding++;
                            for (int i = 0; i < 16; i++)
                                exp_q.push_back(8'(blk_data >> (8 * (15 - i))));
                            if (TRL) begin
                                exp_q.push_back(8'h0D);
                                exp_q.push_back(8'h0A);
                            end
                        end else begin
                            exp_ovf = 1'b1;
                        end
                    end
                    if (real_done) begin
                        seen++;
                        gap_now = 1'b1;
                        if (seen == FB) begin
                            seen    = 0;
                            outstanding--;
                            exp_fin = 1'b1;
                            if (outstanding > 0) rise_next = 1'b1;
                        end else begin
                            rise_next = 1'b1;
                        end
                    end
                end
            end
        end

        initial begin : monitor
            logic       prev_en;
            logic [7:0] held;
            logic [7:0] exp_b;
            prev_en = 1'b0;
            held    = 8'h00;
            n_rise  = 0;
            n_ovf   = 0;
            forever begin
                @(negedge sys_clk);
                if (nrst) begin
                    if (bus.overflow) n_ovf++;
                    if (gap_now)  chk("gap_tx_en", g, 32'(bus.tx_en), 32'd0);
                    if (rise_now) chk("start_tx_en", g, 32'(bus.tx_en), 32'd1);
                    if (exp_fin || bus.send_done)
                        chk("send_done", g, 32'(bus.send_done), 32'(exp_fin));
                    if (exp_ovf || bus.overflow)
                        chk("overflow", g, 32'(bus.overflow), 32'(exp_ovf));
                    chk("busy", g, 32'(bus.busy), 32'((outstanding != 0) || exp_fin));
                    if (bus.tx_en && !prev_en) begin
                        n_rise++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_tx_en", g, 32'(bus.tx_en), 32'd0);
                        end else begin
                            exp_b = exp_q.pop_front();
                            chk("tx_data", g, 32'(bus.tx_data), 32'(exp_b));
                        end
                        held = bus.tx_data;
                    end else if (bus.tx_en) begin
                        chk("tx_data_hold", g, 32'(bus.tx_data), 32'(held));
                    end
                end
                prev_en = bus.tx_en;
            end
        end
    end

    task automatic send_blk(input logic [127:0] d);
        blk_valid = 1'b1;
        blk_data  = d;
        @(negedge sys_clk);
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge sys_clk);
        while ((g_dut[0].bus.busy || g_dut[1].bus.busy) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 0, 32'(g_dut[0].bus.busy), 32'd0);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n;
        n = 0;
        while (g_dut[0].n_rise < target && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= budget) chk("byte_timeout", 0, 32'(g_dut[0].n_rise), 32'(target));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_tx_en"},   0, 32'(g_dut[0].bus.tx_en),   32'd0);
        chk({tag, "_tx_data"}, 0, 32'(g_dut[0].bus.tx_data), 32'd0);
        chk({tag, "_busy"},    0, 32'(g_dut[0].bus.busy),    32'd0);
        chk({tag, "_tx_en"},   1, 32'(g_dut[1].bus.tx_en),   32'd0);
        chk({tag, "_tx_data"}, 1, 32'(g_dut[1].bus.tx_data), 32'd0);
        chk({tag, "_busy"},    1, 32'(g_dut[1].bus.busy),    32'd0);
    endtask

    initial begin : stim
        int base;
        int ovf0;
        n_checks  = 0;
        n_fail    = 0;
        nrst      = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        repeat (3) @(negedge sys_clk);
        check_quiet("reset");
        chk("reset_send_done", 0, 32'(g_dut[0].bus.send_done), 32'd0);
        chk("reset_overflow",  0, 32'(g_dut[0].bus.overflow),  32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Single block.
        send_blk(128'h00112233445566778899aabbccddeeff);
        wait_idle(1000);

        // Back-to-back: B during A's byte 3, C during A's byte 9 is dropped.
        ovf0 = g_dut[0].n_ovf;
        base = g_dut[0].n_rise;
        send_blk(128'h000102030405060708090a0b0c0d0e0f);
        wait_rises(base + 4, 300);
        send_blk(128'h101112131415161718191a1b1c1d1e1f);
        wait_rises(base + 10, 400);
        send_blk(128'h202122232425262728292a2b2c2d2e2f);
        wait_idle(2000);
        chk("b2b_overflow_count", 0, 32'(g_dut[0].n_ovf - ovf0), 32'd1);

        // Block offered in the send_done cycle.
        send_blk(128'hfedcba98765432100123456789abcdef);
        begin
            int n;
            n = 0;
            while (!g_dut[0].bus.send_done && n < 1000) begin
                @(negedge sys_clk);
                n++;
            end
            if (n >= 1000) chk("fin_timeout", 0, 32'(g_dut[0].bus.send_done), 32'd1);
        end
        send_blk(128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf);
        wait_idle(1000);

        // Reset at byte 7 with a block pending.
        base = g_dut[0].n_rise;
        send_blk(128'h303132333435363738393a3b3c3d3e3f);
        wait_rises(base + 2, 300);
        send_blk(128'h404142434445464748494a4b4c4d4e4f);
        wait_rises(base + 8, 400);
        nrst = 1'b0;
        @(negedge sys_clk);
        check_quiet("midreset");
        nrst = 1'b1;
        repeat (40) @(negedge sys_clk);
        chk("post_reset_quiet", 0, 32'(g_dut[0].bus.tx_en), 32'd0);
        chk("post_reset_quiet", 1, 32'(g_dut[1].bus.tx_en), 32'd0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 6000; c++) begin
            blk_valid = ($urandom_range(0, 39) == 0);
            blk_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            nrst      = !($urandom_range(0, 1499) == 0);
            @(negedge sys_clk);
        end
        blk_valid = 1'b0;
        nrst      = 1'b1;
        wait_idle(3000);
        repeat (3) @(negedge sys_clk);
        chk("final_busy",     0, 32'(g_dut[0].bus.busy),     32'd0);
        chk("final_busy",     1, 32'(g_dut[1].bus.busy),     32'd0);
        chk("leftover_bytes", 0, 32'(g_dut[0].exp_q.size()), 32'd0);
        chk("leftover_bytes", 1, 32'(g_dut[1].exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
